// File: rtl/alu_exec.sv
// Multi-cycle ALU execute stage: captures operands on START, commits the result
// and condition codes one cycle later, and holds them until the consumer ACKs.
module alu_exec (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] SR1_IN,
  input  logic [15:0] SR2_IN,
  input  logic [15:0] IR,
  input  logic [1:0]  ALUK,
  input  logic        LD_CC,
  input  logic        START,
  input  logic        ACK,
  output logic [15:0] ALU_OUT,
  output logic        BUSY,
  output logic        DONE,
  output logic        N,
  output logic        Z,
  output logic        P,
  output logic        V
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  aluk_q, aluk_d;
  logic        ld_cc_q, ld_cc_d;
  logic [15:0] alu_out_q, alu_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        n_q, n_d, z_q, z_d, p_q, p_d, v_q, v_d;
  logic [15:0] result_s;
  logic        capture_s;

  function automatic logic add_overflow(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] r);
    add_overflow = (a[15] == b[15]) && (r[15] != a[15]);
  endfunction

  always_comb begin
    case (aluk_q)
      OP_ADD:  result_s = a_q + b_q;
      OP_AND:  result_s = a_q & b_q;
      OP_NOT:  result_s = ~a_q;
      default: result_s = a_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    aluk_d    = aluk_q;
    ld_cc_d   = ld_cc_q;
    alu_out_d = alu_out_q;
    busy_d    = busy_q;
    done_d    = done_q;
    n_d       = n_q;
    z_d       = z_q;
    p_d       = p_q;
    v_d       = v_q;
    capture_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          capture_s = 1'b1;
          state_d   = EXEC;
          busy_d    = 1'b1;
        end
      end
      EXEC: begin
        state_d   = HOLD;
        alu_out_d = result_s;
        done_d    = 1'b1;
        busy_d    = 1'b1;
        if (ld_cc_q) begin
          n_d = result_s[15];
          z_d = (result_s == 16'h0000);
          p_d = !result_s[15] && (result_s != 16'h0000);
        end
        v_d = (aluk_q == OP_ADD) ? add_overflow(a_q, b_q, result_s) : 1'b0;
      end
      HOLD: begin
        if (ACK) begin
          done_d = 1'b0;
          if (START) begin
            capture_s = 1'b1;
            state_d   = EXEC;
            busy_d    = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    // Operands are latched only at acceptance so later input changes cannot leak in.
    if (capture_s) begin
      a_d     = SR1_IN;
      b_d     = IR[5] ? {{11{IR[4]}}, IR[4:0]} : SR2_IN;
      aluk_d  = ALUK;
      ld_cc_d = LD_CC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      aluk_q    <= 2'b00;
      ld_cc_q   <= 1'b0;
      alu_out_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      n_q       <= 1'b0;
      z_q       <= 1'b1;
      p_q       <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluk_q    <= aluk_d;
      ld_cc_q   <= ld_cc_d;
      alu_out_q <= alu_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      n_q       <= n_d;
      z_q       <= z_d;
      p_q       <= p_d;
      v_q       <= v_d;
    end
  end

  assign ALU_OUT = alu_out_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign N       = n_q;
  assign Z       = z_q;
  assign P       = p_q;
  assign V       = v_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed, table-driven bench for alu_exec with hand-computed expected results
// plus handshake-stall, reset-mid-op and back-to-back sequences.
module tb_alu_exec;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] SR1_IN, SR2_IN, IR;
  logic [1:0]  ALUK;
  logic        LD_CC, START, ACK;
  logic [15:0] ALU_OUT;
  logic        BUSY, DONE, N, Z, P, V;

  int errors = 0;
  int checks = 0;

  alu_exec dut (
    .CLK(CLK), .RESET(RESET), .SR1_IN(SR1_IN), .SR2_IN(SR2_IN), .IR(IR),
    .ALUK(ALUK), .LD_CC(LD_CC), .START(START), .ACK(ACK),
    .ALU_OUT(ALU_OUT), .BUSY(BUSY), .DONE(DONE), .N(N), .Z(Z), .P(P), .V(V)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [15:0] ir;
    logic [1:0]  aluk;
    logic        ld_cc;
    logic [15:0] exp_out;
    logic [2:0]  exp_nzp;
    logic        exp_v;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [15:0] sr1, input logic [15:0] sr2,
                         input logic [15:0] ir, input logic [1:0] aluk, input logic ld);
    SR1_IN = sr1; SR2_IN = sr2; IR = ir; ALUK = aluk; LD_CC = ld;
  endtask

  logic [15:0] held_out;
  logic [2:0]  held_nzp;

  initial begin
    RESET = 1'b1; START = 1'b0; ACK = 1'b0;
    set_ops(16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);

    vecs[0] = '{16'h0005, 16'h0000, 16'h003D, 2'b00, 1'b1, 16'h0002, 3'b001, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 16'h0000, 2'b00, 1'b1, 16'h8000, 3'b100, 1'b1};
    vecs[2] = '{16'hF0F0, 16'h0F0F, 16'h0000, 2'b01, 1'b1, 16'h0000, 3'b010, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 2'b10, 1'b0, 16'hFFFF, 3'b010, 1'b0};
    vecs[4] = '{16'h1234, 16'h5555, 16'h0000, 2'b11, 1'b1, 16'h1234, 3'b001, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 16'h0000, 2'b00, 1'b0, 16'h0000, 3'b001, 1'b1};
    vecs[6] = '{16'h0000, 16'h1234, 16'h0030, 2'b00, 1'b1, 16'hFFF0, 3'b100, 1'b0};
    vecs[7] = '{16'h00FF, 16'hFFFF, 16'h002F, 2'b01, 1'b1, 16'h000F, 3'b001, 1'b0};

    step(); step();
    RESET = 1'b0;
    check("reset_out",  ALU_OUT, 16'h0000);
    check("reset_done", {15'd0, DONE}, 16'd0);
    check("reset_busy", {15'd0, BUSY}, 16'd0);
    check("reset_nzp",  {13'd0, N, Z, P}, 16'd2);
    check("reset_v",    {15'd0, V}, 16'd0);

    foreach (vecs[i]) begin
      set_ops(vecs[i].sr1, vecs[i].sr2, vecs[i].ir, vecs[i].aluk, vecs[i].ld_cc);
      START = 1'b1;
      step();
      START = 1'b0;
      set_ops(16'hDEAD, 16'hBEEF, 16'h0000, 2'b00, 1'b1);
      check($sformatf("v%0d_exec_busy", i), {15'd0, BUSY}, 16'd1);
      check($sformatf("v%0d_exec_done", i), {15'd0, DONE}, 16'd0);
      step();
      check($sformatf("v%0d_done", i), {15'd0, DONE}, 16'd1);
      check($sformatf("v%0d_out", i), ALU_OUT, vecs[i].exp_out);
      check($sformatf("v%0d_nzp", i), {13'd0, N, Z, P}, {13'd0, vecs[i].exp_nzp});
      check($sformatf("v%0d_v", i), {15'd0, V}, {15'd0, vecs[i].exp_v});
      ACK = 1'b1;
      step();
      ACK = 1'b0;
      check($sformatf("v%0d_idle_busy", i), {15'd0, BUSY}, 16'd0);
      check($sformatf("v%0d_idle_out", i), ALU_OUT, vecs[i].exp_out);
    end

    // Handshake stall: ADD 0x0100+0x0001, then 5 cycles of noise without ACK.
    set_ops(16'h0100, 16'h0001, 16'h0000, 2'b00, 1'b1);
    START = 1'b1; step(); START = 1'b0; step();
    check("stall_out0", ALU_OUT, 16'h0101);
    held_out = ALU_OUT;
    held_nzp = {N, Z, P};
    for (int k = 0; k < 5; k++) begin
      START = k[0];
      set_ops(16'h7000 + 16'(k), 16'h7000, 16'h0000, 2'(k), 1'b1);
      step();
      check($sformatf("stall%0d_out", k), ALU_OUT, held_out);
      check($sformatf("stall%0d_done", k), {15'd0, DONE}, 16'd1);
      check($sformatf("stall%0d_nzp", k), {13'd0, N, Z, P}, {13'd0, held_nzp});
    end
    set_ops(16'h8000, 16'h0000, 16'h0000, 2'b11, 1'b1);
    ACK = 1'b1; START = 1'b1; step();
    ACK = 1'b0; START = 1'b0;
    check("stall_next_busy", {15'd0, BUSY}, 16'd1);
    check("stall_next_done0", {15'd0, DONE}, 16'd0);
    step();
    check("stall_next_done", {15'd0, DONE}, 16'd1);
    check("stall_next_out", ALU_OUT, 16'h8000);
    check("stall_next_nzp", {13'd0, N, Z, P}, 16'd4);
    ACK = 1'b1; step(); ACK = 1'b0;

    // Reset during EXEC abandons the op (would have set V=1, NZP=100).
    set_ops(16'h7FFF, 16'h0001, 16'h0000, 2'b00, 1'b1);
    START = 1'b1; step(); START = 1'b0;
    RESET = 1'b1; step(); RESET = 1'b0;
    check("rst_mid_out",  ALU_OUT, 16'h0000);
    check("rst_mid_done", {15'd0, DONE}, 16'd0);
    check("rst_mid_busy", {15'd0, BUSY}, 16'd0);
    check("rst_mid_nzp",  {13'd0, N, Z, P}, 16'd2);
    check("rst_mid_v",    {15'd0, V}, 16'd0);
    step();
    check("rst_mid_after_out", ALU_OUT, 16'h0000);

    // START coincident with RESET is dropped.
    RESET = 1'b1; START = 1'b1; step();
    RESET = 1'b0; START = 1'b0; step();
    check("rst_start_busy", {15'd0, BUSY}, 16'd0);
    check("rst_start_done", {15'd0, DONE}, 16'd0);

    // Back-to-back PASSA, each new op started on the ACK cycle.
    set_ops(16'h1111, 16'h0000, 16'h0000, 2'b11, 1'b1);
    START = 1'b1; step(); START = 1'b0; step();
    check("b2b0_out", ALU_OUT, 16'h1111);
    for (int j = 1; j < 4; j++) begin
      set_ops(16'h1111 * 16'(j + 1), 16'h0000, 16'h0000, 2'b11, 1'b1);
      ACK = 1'b1; START = 1'b1; step();
      ACK = 1'b0; START = 1'b0;
      set_ops(16'h0BAD, 16'h0000, 16'h0000, 2'b11, 1'b1);
      check($sformatf("b2b%0d_exec_done", j), {15'd0, DONE}, 16'd0);
      step();
      check($sformatf("b2b%0d_done", j), {15'd0, DONE}, 16'd1);
      check($sformatf("b2b%0d_out", j), ALU_OUT, 16'h1111 * 16'(j + 1));
    end
    ACK = 1'b1; step(); ACK = 1'b0;
    check("b2b_end_busy", {15'd0, BUSY}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
